cart_mem_arbiter: RTL and testbench
===================================

CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

Interface
REQ-001 Parameter: MEM_AW, 18, memory address width; bit MEM_AW-1 selects RAM (1) or ROM (0) region.
REQ-002 CLK  input  1  system clock, all state on rising edge.
REQ-003 RESB  input  1  reset, asynchronous, active-low.
REQ-004 ROM_A  input  17  mapped CPU ROM address.
REQ-005 ROM_CSB  input  1  ROM select, active-low.
REQ-006 RAM_A  input  13  mapped CPU RAM address.
REQ-007 RAM_CSB  input  1  RAM select, active-low.
REQ-008 RDB / WRB  input  1 each  CPU read/write strobes, active-low.
REQ-009 CPU_DI  input  8  CPU write data.
REQ-010 CPU_DO  output  8  CPU read data.
REQ-011 CPU_WAIT  output  1  CPU stall, active-high.
REQ-012 DL_REQ, DL_WE, DL_RAM  input  1 each  loader request level, write, region select (1 = RAM).
REQ-013 DL_A  input  17  loader address; DL_DI  input  8  loader write data.
REQ-014 DL_DO  output  8  loader read data; DL_ACK  output  1  one-cycle completion pulse.
REQ-015 MEM_REQ, MEM_WE  output  1 each; MEM_A  output  MEM_AW; MEM_D  output  8.
REQ-016 MEM_Q  input  8  memory read data; MEM_ACK  input  1  one-cycle completion pulse.

Function
REQ-017 CPU access start ("cpu_edge") SHALL be the cycle where (~ROM_CSB|~RAM_CSB)&(~RDB|~WRB) is 1 and was 0 the previous cycle; on it, address, region (RAM if RAM_CSB low, else ROM), direction (write if WRB low) and CPU_DI SHALL be latched.
REQ-018 CPU write to ROM region SHALL issue no memory request, raise no CPU_WAIT, and be discarded.
REQ-019 CPU_WAIT SHALL be 1 combinationally in the cpu_edge cycle (except REQ-018) and remain 1 until the cycle after MEM_ACK of that CPU access, then 0.
REQ-020 MEM_A SHALL be {0, ROM address} for ROM, {1, zero-fill, RAM_A/DL_A[12:0]} for RAM.
REQ-021 States: IDLE, CPU, DL. IDLE->CPU on cpu_edge or pending CPU flag; IDLE->DL on DL_REQ when neither present; CPU/DL->IDLE on MEM_ACK.
REQ-022 MEM_REQ SHALL rise the cycle after entering CPU/DL decision, stay high with MEM_A/MEM_WE/MEM_D stable until MEM_ACK, and drop the cycle after MEM_ACK.
REQ-023 Simultaneous cpu_edge and DL_REQ in IDLE: CPU wins.
REQ-024 cpu_edge during DL SHALL set pending flag (CPU_WAIT high); after loader MEM_ACK the pending CPU access SHALL be issued before any further loader access.
REQ-025 On CPU read MEM_ACK, CPU_DO SHALL load MEM_Q; otherwise hold last value.
REQ-026 On loader MEM_ACK, DL_ACK SHALL pulse one cycle and DL_DO load MEM_Q on reads; DL_REQ still high the cycle after DL_ACK is a new transaction.
REQ-027 MEM_ACK in IDLE SHALL be ignored.
REQ-028 Worst-case CPU latency: one loader access plus one CPU access.

Reset
REQ-029 RESB low SHALL immediately force IDLE, clear pending flag, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_D=0, CPU_DO=0, DL_DO=0, DL_ACK=0, CPU_WAIT=0; in-flight access abandoned, late MEM_ACK ignored.
REQ-030 Edge detector history SHALL reset to inactive, so a strobe already active at reset release counts as cpu_edge.

Verification
REQ-031 CPU read ROM_A=0x12345, RDB low; memory acks after 3 cycles with 0xA5 -> MEM_A=0x12345, MEM_WE=0, CPU_DO=0xA5, CPU_WAIT falls the cycle after MEM_ACK.
REQ-032 CPU write RAM_A=0x0F80, CPU_DI=0x3C -> MEM_A=0x20F80, MEM_WE=1, MEM_D=0x3C; ROM write -> no MEM_REQ, CPU_WAIT stays 0.
REQ-033 Loader write DL_A=0x00010, DL_DI=0x55 with cpu_edge 1 cycle later -> loader completes, DL_ACK pulses, CPU access issued next with CPU_WAIT high throughout.
REQ-034 Same-cycle cpu_edge and DL_REQ -> CPU served first, then loader.
REQ-035 RESB low while MEM_REQ high, MEM_ACK arrives during reset and after release -> all outputs zero, no DL_ACK, state IDLE.

Source files
------------

// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: shares one external memory port between the CPU
// (ROM/RAM windows, stalled through CPU_WAIT) and a download loader. CPU
// accesses win ties, and a CPU access that arrives during a loader access is
// held pending and served before the next loader access.
module cart_mem_arbiter #(
    parameter int MEM_AW = 18
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic [16:0]       ROM_A,
    input  logic              ROM_CSB,
    input  logic [12:0]       RAM_A,
    input  logic              RAM_CSB,
    input  logic              RDB,
    input  logic              WRB,
    input  logic [7:0]        CPU_DI,
    output logic [7:0]        CPU_DO,
    output logic              CPU_WAIT,
    input  logic              DL_REQ,
    input  logic              DL_WE,
    input  logic              DL_RAM,
    input  logic [16:0]       DL_A,
    input  logic [7:0]        DL_DI,
    output logic [7:0]        DL_DO,
    output logic              DL_ACK,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [MEM_AW-1:0] MEM_A,
    output logic [7:0]        MEM_D,
    input  logic [7:0]        MEM_Q,
    input  logic              MEM_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DL   = 2'd2
    } state_t;

    // RAM region: top bit set, 13-bit offset; ROM region: top bit clear, 17-bit offset.
    function automatic logic [MEM_AW-1:0] map_addr(input logic ram, input logic [16:0] a);
        logic [MEM_AW-1:0] r;
        r = '0;
        if (ram) begin
            r[MEM_AW-1] = 1'b1;
            r[12:0]     = a[12:0];
        end else begin
            r[16:0] = a;
        end
        return r;
    endfunction

    state_t             state_r;
    logic               cpu_act_prev_r;
    logic               cpu_pend_r;
    logic               cpu_wait_r;
    logic               cpu_ram_r;
    logic               cpu_we_r;
    logic [16:0]        cpu_a_r;
    logic [7:0]         cpu_d_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [MEM_AW-1:0]  mem_a_r;
    logic [7:0]         mem_d_r;
    logic [7:0]         cpu_do_r;
    logic [7:0]         dl_do_r;
    logic               dl_ack_r;

    logic               cpu_act_s;
    logic               cpu_edge_s;
    logic               cpu_ram_s;
    logic               cpu_wr_s;
    logic               cpu_take_s;
    logic [16:0]        cpu_a_s;
    logic               nx_ram_s;
    logic               nx_we_s;
    logic [16:0]        nx_a_s;
    logic [7:0]         nx_d_s;

    assign cpu_act_s  = (~ROM_CSB | ~RAM_CSB) & (~RDB | ~WRB);
    assign cpu_edge_s = cpu_act_s & ~cpu_act_prev_r;
    assign cpu_ram_s  = ~RAM_CSB;
    assign cpu_wr_s   = ~WRB;
    assign cpu_a_s    = cpu_ram_s ? {4'b0000, RAM_A} : ROM_A;
    // ROM writes are dropped at the edge: they never stall or reach memory.
    assign cpu_take_s = cpu_edge_s & ~(~cpu_ram_s & cpu_wr_s);

    // Stall is raised combinationally on the access edge so the CPU never
    // samples stale data; reset overrides it.
    assign CPU_WAIT = (cpu_take_s & RESB) | cpu_wait_r;
    assign CPU_DO   = cpu_do_r;
    assign DL_DO    = dl_do_r;
    assign DL_ACK   = dl_ack_r;
    assign MEM_REQ  = mem_req_r;
    assign MEM_WE   = mem_we_r;
    assign MEM_A    = mem_a_r;
    assign MEM_D    = mem_d_r;

    // Select the CPU access to issue: a fresh edge uses live inputs, otherwise the latched one.
    always_comb begin
        nx_ram_s = cpu_ram_r;
        nx_we_s  = cpu_we_r;
        nx_a_s   = cpu_a_r;
        nx_d_s   = cpu_d_r;
        if (cpu_take_s) begin
            nx_ram_s = cpu_ram_s;
            nx_we_s  = cpu_wr_s;
            nx_a_s   = cpu_a_s;
            nx_d_s   = CPU_DI;
        end else begin
            nx_ram_s = cpu_ram_r;
            nx_we_s  = cpu_we_r;
            nx_a_s   = cpu_a_r;
            nx_d_s   = cpu_d_r;
        end
    end

    // Strobe history for edge detection; cleared so a strobe held through reset counts as new.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            cpu_act_prev_r <= 1'b0;
        end else begin
            cpu_act_prev_r <= cpu_act_s;
        end
    end

    // Stall register: set on an accepted edge, cleared by the ack of the last outstanding CPU access.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            cpu_wait_r <= 1'b0;
        end else if (cpu_take_s) begin
            cpu_wait_r <= 1'b1;
        end else if ((state_r == ST_CPU) && MEM_ACK && !cpu_pend_r) begin
            cpu_wait_r <= 1'b0;
        end else begin
            cpu_wait_r <= cpu_wait_r;
        end
    end

    // Arbitration FSM with registered memory-port and completion outputs.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_r    <= ST_IDLE;
            cpu_pend_r <= 1'b0;
            cpu_ram_r  <= 1'b0;
            cpu_we_r   <= 1'b0;
            cpu_a_r    <= 17'd0;
            cpu_d_r    <= 8'd0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_a_r    <= '0;
            mem_d_r    <= 8'd0;
            cpu_do_r   <= 8'd0;
            dl_do_r    <= 8'd0;
            dl_ack_r   <= 1'b0;
        end else begin
            dl_ack_r <= 1'b0;
            if (cpu_take_s) begin
                cpu_ram_r <= cpu_ram_s;
                cpu_we_r  <= cpu_wr_s;
                cpu_a_r   <= cpu_a_s;
                cpu_d_r   <= CPU_DI;
            end else begin
                cpu_ram_r <= cpu_ram_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cpu_take_s || cpu_pend_r) begin
                        state_r    <= ST_CPU;
                        cpu_pend_r <= 1'b0;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= nx_we_s;
                        mem_a_r    <= map_addr(nx_ram_s, nx_a_s);
                        mem_d_r    <= nx_d_s;
                    end else if (DL_REQ && !dl_ack_r) begin
                        // The ack cycle itself is skipped so the loader can drop its request.
                        state_r   <= ST_DL;
                        mem_req_r <= 1'b1;
                        mem_we_r  <= DL_WE;
                        mem_a_r   <= map_addr(DL_RAM, DL_A);
                        mem_d_r   <= DL_DI;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CPU: begin
                    if (cpu_take_s) begin
                        cpu_pend_r <= 1'b1;
                    end else begin
                        cpu_pend_r <= cpu_pend_r;
                    end
                    if (MEM_ACK) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        if (!mem_we_r) begin
                            cpu_do_r <= MEM_Q;
                        end else begin
                            cpu_do_r <= cpu_do_r;
                        end
                    end else begin
                        state_r <= ST_CPU;
                    end
                end
                ST_DL: begin
                    if (cpu_take_s) begin
                        cpu_pend_r <= 1'b1;
                    end else begin
                        cpu_pend_r <= cpu_pend_r;
                    end
                    if (MEM_ACK) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        dl_ack_r  <= 1'b1;
                        if (!mem_we_r) begin
                            dl_do_r <= MEM_Q;
                        end else begin
                            dl_do_r <= dl_do_r;
                        end
                    end else begin
                        state_r <= ST_DL;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: a transaction-level model predicts
// the memory requests and read data in service order; a memory responder with
// random latency answers requests; a monitor checks what the DUT presents.
module tb_cart_mem_arbiter;
    localparam int MEM_AW = 18;

    logic              CLK = 1'b0;
    logic              RESB;
    logic [16:0]       ROM_A;
    logic              ROM_CSB;
    logic [12:0]       RAM_A;
    logic              RAM_CSB;
    logic              RDB;
    logic              WRB;
    logic [7:0]        CPU_DI;
    logic [7:0]        CPU_DO;
    logic              CPU_WAIT;
    logic              DL_REQ;
    logic              DL_WE;
    logic              DL_RAM;
    logic [16:0]       DL_A;
    logic [7:0]        DL_DI;
    logic [7:0]        DL_DO;
    logic              DL_ACK;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [MEM_AW-1:0] MEM_A;
    logic [7:0]        MEM_D;
    logic [7:0]        MEM_Q;
    logic              MEM_ACK;

    cart_mem_arbiter #(.MEM_AW(MEM_AW)) dut (
        .CLK(CLK), .RESB(RESB), .ROM_A(ROM_A), .ROM_CSB(ROM_CSB), .RAM_A(RAM_A),
        .RAM_CSB(RAM_CSB), .RDB(RDB), .WRB(WRB), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO),
        .CPU_WAIT(CPU_WAIT), .DL_REQ(DL_REQ), .DL_WE(DL_WE), .DL_RAM(DL_RAM),
        .DL_A(DL_A), .DL_DI(DL_DI), .DL_DO(DL_DO), .DL_ACK(DL_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_D(MEM_D),
        .MEM_Q(MEM_Q), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [17:0] a; logic we; logic [7:0] d; } req_t;
    typedef struct packed { logic rd; logic [7:0] d; } rsp_t;

    req_t       req_q[$];
    rsp_t       cpu_q[$];
    rsp_t       dl_q[$];
    logic [7:0] mem_arr[int];
    logic [7:0] ref_mem[int];
    int         compared = 0;
    int         mismatched = 0;
    bit         mon_en = 1'b1;
    bit         hold = 1'b0;
    bit         force_ack = 1'b0;
    int         lat_fix = 0;
    int         lat = 2;
    int         cnt = 0;

    function automatic logic [7:0] def_val(input int a);
        logic [31:0] x;
        x = a;
        return x[7:0] ^ x[15:8] ^ 8'h5A;
    endfunction

    function automatic int maddr(input bit ram, input logic [16:0] a);
        if (ram) return 32'h0002_0000 + int'(a[12:0]);
        return int'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one memory access, in service order.
    function automatic void model_acc(input bit is_cpu, input bit ram, input bit wr,
                                      input logic [16:0] a, input logic [7:0] d);
        int   key;
        rsp_t r;
        key = maddr(ram, a);
        req_q.push_back({key[17:0], wr, d});
        r.rd = !wr;
        r.d  = ref_mem.exists(key) ? ref_mem[key] : def_val(key);
        if (wr) ref_mem[key] = d;
        if (is_cpu) cpu_q.push_back(r);
        else dl_q.push_back(r);
    endfunction

    function automatic void model_cpu(input bit ram, input bit wr, input logic [16:0] a,
                                      input logic [7:0] d);
        if (!(!ram && wr)) model_acc(1'b1, ram, wr, a, d);
    endfunction

    // Memory responder with random latency.
    initial begin
        int key;
        MEM_ACK = 1'b0;
        MEM_Q   = 8'h00;
        forever begin
            @(posedge CLK); #1;
            MEM_ACK = 1'b0;
            if (force_ack) begin
                MEM_ACK = 1'b1;
                MEM_Q   = 8'hEE;
            end else if (!RESB) begin
                cnt = 0;
            end else if (MEM_REQ && !hold) begin
                cnt++;
                if (cnt >= lat) begin
                    MEM_ACK = 1'b1;
                    key = int'(MEM_A);
                    if (MEM_WE) mem_arr[key] = MEM_D;
                    else MEM_Q = mem_arr.exists(key) ? mem_arr[key] : def_val(key);
                    cnt = 0;
                    lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                end
            end
        end
    end

    // Monitor: compares presented requests and completions with the scoreboard.
    initial begin
        bit   p_req = 1'b0;
        bit   p_wait = 1'b0;
        logic [26:0] p_bus = '0;
        req_t e;
        rsp_t r;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (MEM_REQ && !p_req) begin
                    if (req_q.size() == 0) check("unexpected_req", {46'd0, MEM_A}, 64'd0);
                    else begin
                        e = req_q.pop_front();
                        check("mem_a", MEM_A, e.a);
                        check("mem_we", MEM_WE, e.we);
                        if (e.we) check("mem_d", MEM_D, e.d);
                    end
                end
                if (MEM_REQ && p_req) check("mem_stable", {MEM_A, MEM_WE, MEM_D}, p_bus);
                if (!CPU_WAIT && p_wait) begin
                    if (cpu_q.size() == 0) check("unexpected_cpu_done", 64'd1, 64'd0);
                    else begin
                        r = cpu_q.pop_front();
                        if (r.rd) check("cpu_do", CPU_DO, r.d);
                    end
                end
                if (DL_ACK) begin
                    if (dl_q.size() == 0) check("unexpected_dl_ack", 64'd1, 64'd0);
                    else begin
                        r = dl_q.pop_front();
                        if (r.rd) check("dl_do", DL_DO, r.d);
                    end
                end
            end
            p_req  = MEM_REQ;
            p_wait = CPU_WAIT;
            p_bus  = {MEM_A, MEM_WE, MEM_D};
        end
    end

    task automatic cpu_op(input bit ram, input bit wr, input logic [16:0] a,
                          input logic [7:0] d, input int exp_acks, input bit push);
        int n;
        int acks;
        int last;
        if (push) model_cpu(ram, wr, a, d);
        @(posedge CLK); #1;
        RAM_CSB = ~ram; ROM_CSB = ram; WRB = ~wr; RDB = wr;
        RAM_A = a[12:0]; ROM_A = a; CPU_DI = d;
        @(negedge CLK);
        if (!ram && wr) begin
            check("rom_wr_wait", CPU_WAIT, 1'b0);
            repeat (3) begin
                @(negedge CLK);
                check("rom_wr_req", {MEM_REQ, CPU_WAIT}, 2'b00);
            end
        end else begin
            check("wait_on_edge", CPU_WAIT, 1'b1);
            n = 0; acks = 0; last = -10;
            while (CPU_WAIT && n < 200) begin
                if (MEM_ACK) begin acks++; last = n; end
                @(negedge CLK);
                n++;
            end
            check("wait_timeout", n < 200, 1'b1);
            check("wait_fall_after_ack", n - last, 1);
            check("ack_count", acks, exp_acks);
        end
        @(posedge CLK); #1;
        RAM_CSB = 1'b1; ROM_CSB = 1'b1; WRB = 1'b1; RDB = 1'b1;
    endtask

    task automatic dl_op(input bit ram, input bit we, input logic [16:0] a,
                         input logic [7:0] d, input bit push);
        int n;
        if (push) model_acc(1'b0, ram, we, a, d);
        @(posedge CLK); #1;
        DL_REQ = 1'b1; DL_RAM = ram; DL_WE = we; DL_A = a; DL_DI = d;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DL_ACK && n < 200);
        check("dl_ack_seen", DL_ACK, 1'b1);
        @(posedge CLK); #1;
        DL_REQ = 1'b0;
        @(negedge CLK);
        check("dl_ack_pulse", DL_ACK, 1'b0);
    endtask

    function automatic logic [16:0] rnd_a();
        return 17'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
    endfunction

    initial begin
        int n;
        bit ram, wr;
        logic [16:0] a, a2;
        logic [7:0] d, d2;
        RESB = 1'b0;
        ROM_CSB = 1'b0; RDB = 1'b0; RAM_CSB = 1'b1; WRB = 1'b1;
        ROM_A = 17'h00ABC; RAM_A = 13'd0; CPU_DI = 8'd0;
        DL_REQ = 1'b0; DL_WE = 1'b0; DL_RAM = 1'b0; DL_A = 17'd0; DL_DI = 8'd0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {MEM_REQ, MEM_WE, MEM_A, MEM_D, CPU_DO, DL_DO, DL_ACK, CPU_WAIT}, 64'd0);
        // Strobe held through reset release counts as a new access.
        model_cpu(1'b0, 1'b0, 17'h00ABC, 8'h00);
        RESB = 1'b1;
        #1 check("edge_at_release", CPU_WAIT, 1'b1);
        n = 0;
        while (CPU_WAIT && n < 200) begin @(negedge CLK); n++; end
        check("release_access_done", CPU_WAIT, 1'b0);
        @(posedge CLK); #1;
        ROM_CSB = 1'b1; RDB = 1'b1;

        // ROM read with fixed 3-cycle latency returning 0xA5.
        mem_arr[32'h12345] = 8'hA5; ref_mem[32'h12345] = 8'hA5;
        lat_fix = 3; lat = 3;
        cpu_op(1'b0, 1'b0, 17'h12345, 8'h00, 1, 1'b1);
        check("directed_cpu_do", CPU_DO, 8'hA5);
        lat_fix = 0;
        // RAM write, then discarded ROM write.
        cpu_op(1'b1, 1'b1, 17'h00F80, 8'h3C, 1, 1'b1);
        cpu_op(1'b0, 1'b1, 17'h00F80, 8'h77, 0, 1'b1);
        // Loader write, CPU read of the same ROM byte one cycle later.
        model_acc(1'b0, 1'b0, 1'b1, 17'h00010, 8'h55);
        model_cpu(1'b0, 1'b0, 17'h00010, 8'h00);
        fork
            dl_op(1'b0, 1'b1, 17'h00010, 8'h55, 1'b0);
            begin @(posedge CLK); cpu_op(1'b0, 1'b0, 17'h00010, 8'h00, 2, 1'b0); end
        join
        check("dl_then_cpu_data", CPU_DO, 8'h55);

        // Random CPU-only traffic.
        for (int i = 0; i < 30; i++) begin
            ram = 1'($urandom); wr = 1'($urandom); a = rnd_a(); d = 8'($urandom);
            cpu_op(ram, wr, a, d, 1, 1'b1);
        end
        // Random loader-only traffic.
        for (int i = 0; i < 20; i++) begin
            ram = 1'($urandom); wr = 1'($urandom); a = rnd_a(); d = 8'($urandom);
            dl_op(ram, wr, a, d, 1'b1);
        end
        // Collisions: same-cycle (CPU first) and loader-first with a late CPU edge.
        for (int i = 0; i < 12; i++) begin
            ram = 1'($urandom); wr = 1'($urandom) & ram; a = rnd_a(); d = 8'($urandom);
            a2 = rnd_a(); d2 = 8'($urandom);
            if (i % 2 == 0) begin
                model_cpu(ram, wr, a, d);
                model_acc(1'b0, ~ram, 1'($urandom), a2, d2);
                fork
                    cpu_op(ram, wr, a, d, 1, 1'b0);
                    dl_op(req_q[1].a[17], req_q[1].we, a2, d2, 1'b0);
                join
            end else begin
                model_acc(1'b0, ~ram, 1'($urandom), a2, d2);
                model_cpu(ram, wr, a, d);
                fork
                    dl_op(req_q[0].a[17], req_q[0].we, a2, d2, 1'b0);
                    begin @(posedge CLK); cpu_op(ram, wr, a, d, 2, 1'b0); end
                join
            end
        end

        // Reset in flight with acks during and after reset.
        mon_en = 1'b0; hold = 1'b1;
        @(posedge CLK); #1;
        ROM_CSB = 1'b0; RDB = 1'b0; ROM_A = 17'h01234;
        repeat (3) @(negedge CLK);
        check("rst_pre_req", MEM_REQ, 1'b1);
        RESB = 1'b0;
        #1 check("rst_outputs", {MEM_REQ, MEM_WE, MEM_A, MEM_D, CPU_DO, DL_DO, DL_ACK, CPU_WAIT}, 64'd0);
        force_ack = 1'b1;
        @(negedge CLK);
        force_ack = 1'b0; ROM_CSB = 1'b1; RDB = 1'b1;
        @(negedge CLK);
        RESB = 1'b1; force_ack = 1'b1;
        @(negedge CLK);
        force_ack = 1'b0; hold = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_idle", {MEM_REQ, MEM_WE, MEM_A, MEM_D, CPU_DO, DL_DO, DL_ACK, CPU_WAIT}, 64'd0);
        end
        mon_en = 1'b1;
        cpu_op(1'b1, 1'b0, 17'h00022, 8'h00, 1, 1'b1);

        repeat (5) @(negedge CLK);
        check("req_q_empty", req_q.size(), 0);
        check("cpu_q_empty", cpu_q.size(), 0);
        check("dl_q_empty", dl_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
